mux_sram_bus_ctrl: RTL and testbench

Parametrised external-memory bus controller for the moonbase CPU family. Replaces the fixed one-cycle address-latch / 4-bit-data pin protocol with several generalisations:
- configurable data and address widths
- multi-chunk address phases over a narrow multiplexed AD bus
- programmable and pin-extended wait states
- a valid/ready core-side request port
It sits between the CPU core's load/store unit and the chip pins that drive an external latch plus SRAM.

---
 rtl/mux_sram_bus_ctrl_if.sv | 39 +++
 rtl/mux_sram_bus_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mux_sram_bus_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sram_bus_ctrl_if.sv
// Core request/response port and external SRAM pin bundle for mux_sram_bus_ctrl.
// The master modport is the controller's view; the slave modport is the core plus the SRAM pads.
interface mux_sram_bus_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 7,
  parameter int AD_W   = 7
);
  localparam int NCHUNK  = (ADDR_W + AD_W - 1) / AD_W;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  logic               pin_ale;
  logic [CHUNK_W-1:0] pin_ale_sel;
  logic [AD_W-1:0]    pin_ad;
  logic               pin_ad_oe;
  logic               pin_we_n;
  logic               pin_oe_n;
  logic [DATA_W-1:0]  pin_din;
  logic               pin_wait;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, pin_din, pin_wait,
    output req_ready, rsp_valid, rsp_rdata,
    output pin_ale, pin_ale_sel, pin_ad, pin_ad_oe, pin_we_n, pin_oe_n
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, pin_din, pin_wait,
    input  req_ready, rsp_valid, rsp_rdata,
    input  pin_ale, pin_ale_sel, pin_ad, pin_ad_oe, pin_we_n, pin_oe_n
  );
endinterface

// File: rtl/mux_sram_bus_ctrl.sv
// Multiplexed address/data SRAM bus controller: chunked ALE address phase, waited data phase.
// Optional macro SRAM_ADDR_SKIP_EN skips the address phase when the address repeats.
module mux_sram_bus_ctrl #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 7,
  parameter int AD_W        = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  mux_sram_bus_ctrl_if.master bus
);
  localparam int NCHUNK  = (ADDR_W + AD_W - 1) / AD_W;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W   = NCHUNK * AD_W;
  localparam int DCNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_TURN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CHUNK_W-1:0] r_chunk;
  logic [CHUNK_W-1:0] w_chunk_nxt;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [DCNT_W-1:0]  w_dcnt_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ale;
  logic [CHUNK_W-1:0] r_ale_sel;
  logic [AD_W-1:0]    r_ad;
  logic               r_ad_oe;
  logic               r_we_n;
  logic               r_oe_n;

  logic               w_req_ready_nxt;
  logic               w_rsp_valid_nxt;
  logic [DATA_W-1:0]  w_rdata_nxt;
  logic               w_ale_nxt;
  logic [CHUNK_W-1:0] w_ale_sel_nxt;
  logic [AD_W-1:0]    w_ad_nxt;
  logic               w_ad_oe_nxt;
  logic               w_we_n_nxt;
  logic               w_oe_n_nxt;

  logic              w_accept;
  logic              w_last_chunk;
  logic              w_min_reached;
  logic              w_data_done;
  logic              w_skip;
  logic              w_we_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic [DATA_W-1:0] w_wdata_eff;
  logic [PAD_W-1:0]  w_addr_pad;

  // r_req_ready rather than the state gates acceptance, so the first cycle after reset ignores req_valid
  assign w_accept      = (r_state == S_IDLE) && r_req_ready && bus.req_valid;
  assign w_last_chunk  = (r_chunk == CHUNK_W'(NCHUNK - 1));
  assign w_min_reached = (r_dcnt == DCNT_W'(WAIT_STATES));
  assign w_data_done   = w_min_reached && !bus.pin_wait;

`ifdef SRAM_ADDR_SKIP_EN
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_valid;

  assign w_skip = r_last_valid && (bus.req_addr == r_last_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
    end else if ((r_state == S_ADDR) && w_last_chunk) begin
      r_last_addr  <= r_addr;
      r_last_valid <= 1'b1;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // Pins are computed from the upcoming state so every output is a flop aligned with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_chunk     <= '0;
      r_dcnt      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_ale       <= 1'b0;
      r_ale_sel   <= '0;
      r_ad        <= '0;
      r_ad_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_chunk     <= w_chunk_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_we        <= w_we_eff;
      r_addr      <= w_addr_eff;
      r_wdata     <= w_wdata_eff;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ale       <= w_ale_nxt;
      r_ale_sel   <= w_ale_sel_nxt;
      r_ad        <= w_ad_nxt;
      r_ad_oe     <= w_ad_oe_nxt;
      r_we_n      <= w_we_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chunk_nxt = r_chunk;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_chunk_nxt = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = w_skip ? S_DATA : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_last_chunk) begin
          w_state_nxt = S_DATA;
          w_dcnt_nxt  = '0;
        end else begin
          w_chunk_nxt = r_chunk + 1'b1;
        end
      end
      // The counter saturates at the minimum; from there pin_wait alone decides when to leave
      S_DATA: begin
        if (w_data_done) begin
          w_state_nxt = S_TURN;
        end else if (!w_min_reached) begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      S_TURN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_we_eff    = w_accept ? bus.req_we    : r_we;
  assign w_addr_eff  = w_accept ? bus.req_addr  : r_addr;
  assign w_wdata_eff = w_accept ? bus.req_wdata : r_wdata;
  assign w_addr_pad  = PAD_W'(w_addr_eff);

  always_comb begin
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_ale_nxt       = 1'b0;
    w_ale_sel_nxt   = '0;
    w_ad_nxt        = '0;
    w_ad_oe_nxt     = 1'b0;
    w_we_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    case (w_state_nxt)
      S_IDLE: w_req_ready_nxt = 1'b1;
      S_ADDR: begin
        w_ale_nxt     = 1'b1;
        w_ale_sel_nxt = w_chunk_nxt;
        w_ad_nxt      = AD_W'(w_addr_pad >> (AD_W * int'(w_chunk_nxt)));
        w_ad_oe_nxt   = 1'b1;
      end
      S_DATA: begin
        if (w_we_eff) begin
          w_ad_nxt    = AD_W'(w_wdata_eff);
          w_ad_oe_nxt = 1'b1;
          w_we_n_nxt  = 1'b0;
        end else begin
          w_oe_n_nxt  = 1'b0;
        end
      end
      S_TURN:  w_rsp_valid_nxt = 1'b1;
      default: w_req_ready_nxt = 1'b0;
    endcase
    if ((r_state == S_DATA) && (w_state_nxt == S_TURN) && !r_we) begin
      w_rdata_nxt = bus.pin_din;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.pin_ale     = r_ale;
  assign bus.pin_ale_sel = r_ale_sel;
  assign bus.pin_ad      = r_ad;
  assign bus.pin_ad_oe   = r_ad_oe;
  assign bus.pin_we_n    = r_we_n;
  assign bus.pin_oe_n    = r_oe_n;
endmodule

// File: tb/tb_mux_sram_bus_ctrl.sv
// Directed self-checking bench: busA/dutA use default parameters, busB/dutB use
// ADDR_W=12, WAIT_STATES=2 to exercise two-chunk addresses and programmed wait states.
module tb_mux_sram_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  mux_sram_bus_ctrl_if #(.DATA_W(4), .ADDR_W(7),  .AD_W(7)) busA ();
  mux_sram_bus_ctrl_if #(.DATA_W(4), .ADDR_W(12), .AD_W(7)) busB ();

  mux_sram_bus_ctrl #(.DATA_W(4), .ADDR_W(7), .AD_W(7), .WAIT_STATES(0)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  mux_sram_bus_ctrl #(.DATA_W(4), .ADDR_W(12), .AD_W(7), .WAIT_STATES(2)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkA(input string tag, input logic ale, input logic [6:0] ad, input logic adOe,
                        input logic weN, input logic oeN, input logic rspValid);
    checkOutput({tag, ".ale"},   32'(busA.pin_ale),   32'(ale));
    checkOutput({tag, ".ad"},    32'(busA.pin_ad),    32'(ad));
    checkOutput({tag, ".adOe"},  32'(busA.pin_ad_oe), 32'(adOe));
    checkOutput({tag, ".weN"},   32'(busA.pin_we_n),  32'(weN));
    checkOutput({tag, ".oeN"},   32'(busA.pin_oe_n),  32'(oeN));
    checkOutput({tag, ".rspV"},  32'(busA.rsp_valid), 32'(rspValid));
  endtask

  task automatic checkB(input string tag, input logic ale, input logic sel, input logic [6:0] ad,
                        input logic adOe, input logic oeN, input logic rspValid);
    checkOutput({tag, ".ale"},  32'(busB.pin_ale),     32'(ale));
    checkOutput({tag, ".sel"},  32'(busB.pin_ale_sel), 32'(sel));
    checkOutput({tag, ".ad"},   32'(busB.pin_ad),      32'(ad));
    checkOutput({tag, ".adOe"}, 32'(busB.pin_ad_oe),   32'(adOe));
    checkOutput({tag, ".oeN"},  32'(busB.pin_oe_n),    32'(oeN));
    checkOutput({tag, ".rspV"}, 32'(busB.rsp_valid),   32'(rspValid));
  endtask

  task automatic applyStimulus(input bit toB, input logic valid, input logic we,
                               input logic [11:0] addr, input logic [3:0] wdata);
    if (toB) begin
      busB.req_valid = valid;
      busB.req_we    = we;
      busB.req_addr  = addr;
      busB.req_wdata = wdata;
    end else begin
      busA.req_valid = valid;
      busA.req_we    = we;
      busA.req_addr  = addr[6:0];
      busA.req_wdata = wdata;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    busA.pin_din = '0;
    busA.pin_wait = 1'b0;
    busB.pin_din = '0;
    busB.pin_wait = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 4'h0);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 12'($urandom), 4'($urandom));
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), 12'($urandom), 4'($urandom));
      busA.pin_din  = 4'($urandom);
      busA.pin_wait = 1'($urandom);
      busB.pin_din  = 4'($urandom);
      busB.pin_wait = 1'($urandom);
      step(1);
    end
    checkA("rstA", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rstA.ready", 32'(busA.req_ready), 32'd0);
    checkOutput("rstA.rdata", 32'(busA.rsp_rdata), 32'd0);
    checkOutput("rstA.sel",   32'(busA.pin_ale_sel), 32'd0);
    checkB("rstB", 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("rstB.weN",   32'(busB.pin_we_n), 32'd1);
    checkOutput("rstB.ready", 32'(busB.req_ready), 32'd0);
    checkOutput("rstB.rdata", 32'(busB.rsp_rdata), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 4'h0);
    busA.pin_wait = 1'b0;
    busB.pin_wait = 1'b0;
    busA.pin_din  = 4'h0;
    busB.pin_din  = 4'h0;
    rst = 1'b1;
    #1;
    checkOutput("rel.readyBeforeEdge", 32'(busA.req_ready), 32'd0);
    step(1);
    checkOutput("rel.readyA", 32'(busA.req_ready), 32'd1);
    checkOutput("rel.readyB", 32'(busB.req_ready), 32'd1);

    // Single-chunk write, no wait states
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h50, 4'hA);
    step(1);
    checkA("wr.addr", 1'b1, 7'h50, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("wr.addr.ready", 32'(busA.req_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkA("wr.data", 1'b0, 7'h0A, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    checkA("wr.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("wr.turn.ready", 32'(busA.req_ready), 32'd0);
    checkOutput("wr.turn.rdata", 32'(busA.rsp_rdata), 32'd0);
    step(1);
    checkA("wr.idle", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("wr.idle.ready", 32'(busA.req_ready), 32'd1);

    // Read stretched by four pin_wait samples
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h11, 4'h0);
    busA.pin_din = 4'h3;
    step(1);
    checkA("rdw.addr", 1'b1, 7'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkA("rdw.data0", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    busA.pin_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkA($sformatf("rdw.wait%0d", i), 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("rdw.rdataHeld", 32'(busA.rsp_rdata), 32'd0);
    busA.pin_wait = 1'b0;
    busA.pin_din  = 4'h9;
    step(1);
    checkA("rdw.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rdw.rdata", 32'(busA.rsp_rdata), 32'd9);
    step(1);
    checkOutput("rdw.idle.rspV", 32'(busA.rsp_valid), 32'd0);

    // Reset during the data phase of a write
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h22, 4'h5);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkA("abort.data", 1'b0, 7'h05, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkA("abort.rst", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("abort.rst.rdata", 32'(busA.rsp_rdata), 32'd0);
    step(2);
    rst = 1'b1;
    step(1);
    checkOutput("abort.rel.ready", 32'(busA.req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1);
      checkOutput($sformatf("abort.noRsp%0d", i), 32'(busA.rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h33, 4'h0);
    busA.pin_din = 4'h7;
    step(1);
    checkA("post.addr", 1'b1, 7'h33, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkA("post.data", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkA("post.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("post.rdata", 32'(busA.rsp_rdata), 32'd7);
    step(1);

    // Two-chunk address, two wait states
    applyStimulus(1'b1, 1'b1, 1'b0, 12'hABC, 4'h0);
    busB.pin_din = 4'h6;
    step(1);
    checkB("b.chunk0", 1'b1, 1'b0, 7'h3C, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkB("b.chunk1", 1'b1, 1'b1, 7'h15, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkB($sformatf("b.data%0d", i), 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
    end
    step(1);
    checkB("b.turn", 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("b.rdata", 32'(busB.rsp_rdata), 32'd6);
    step(1);
    checkOutput("b.idle.rspV",  32'(busB.rsp_valid), 32'd0);
    checkOutput("b.idle.ready", 32'(busB.req_ready), 32'd1);

    // Repeated address: skipped address phase only when the feature is built
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h23, 4'h0);
    busA.pin_din = 4'h2;
    step(1);
    checkA("rep1.addr", 1'b1, 7'h23, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(2);
    checkA("rep1.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rep1.rdata", 32'(busA.rsp_rdata), 32'd2);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h23, 4'h0);
    busA.pin_din = 4'h4;
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
`ifdef SRAM_ADDR_SKIP_EN
    checkA("rep2.skipData", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
`else
    checkA("rep2.addr", 1'b1, 7'h23, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    checkA("rep2.data", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
`endif
    checkA("rep2.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rep2.rdata", 32'(busA.rsp_rdata), 32'd4);
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h23, 4'hF);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(3);
    checkOutput("wr2.rdataKept", 32'(busA.rsp_rdata), 32'd4);
    checkOutput("wr2.ready",     32'(busA.req_ready), 32'd1);

    rst = 1'b0;
    #2;
    rst = 1'b1;
    step(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h23, 4'h0);
    busA.pin_din = 4'h1;
    step(1);
    checkA("rep3.addr", 1'b1, 7'h23, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0);
    step(1);
    checkA("rep3.data", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkA("rep3.turn", 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rep3.rdata", 32'(busA.rsp_rdata), 32'd1);
    step(1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
